// File: rtl/execute_div.sv
// -----------------------------------------------------------------------------
// execute_div
//
// Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU ops in
// the execute stage. Operands come straight from the decode pipeline register.
// While a divide is in flight, E_stall_o freezes fetch/decode and the decode
// register. The result is registered, and it is flagged by a one-cycle
// E_div_done_o pulse.
//
// Ports:
//   clk_i          clock
//   rst            asynchronous active-high reset
//   E_div_start_i  decode register holds a divide instruction
//   E_div_op_i     0=DIV 1=DIVU 2=REM 3=REMU
//   E_rs1_data_i   dividend
//   E_rs2_data_i   divisor
//   E_flush_i      branch mispredict flush; aborts an in-flight op
//   E_stall_o      hold upstream stages (combinational)
//   E_div_done_o   result valid this cycle
//   E_div_result_o quotient or remainder (held until the next load)
//
// Optional feature: define DIV_RESULT_CACHE_EN to keep the operands and the
// results of the last completed iterative divide. A matching op that follows
// (for example REM after DIV) then completes in one cycle.
// -----------------------------------------------------------------------------
module execute_div #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst,
    input  logic            E_div_start_i,
    input  logic [1:0]      E_div_op_i,
    input  logic [XLEN-1:0] E_rs1_data_i,
    input  logic [XLEN-1:0] E_rs2_data_i,
    input  logic            E_flush_i,
    output logic            E_stall_o,
    output logic            E_div_done_o,
    output logic [XLEN-1:0] E_div_result_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]       state_reg;
    logic [1:0]       op_reg;
    logic [XLEN-1:0]  dvd_reg;      // dividend; quotient bits shift in from the LSB
    logic [XLEN-1:0]  dvs_reg;
    logic [XLEN-1:0]  rem_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             q_neg_reg;
    logic             r_neg_reg;
    logic [XLEN-1:0]  result_reg;

    // ---------------- operand decode (IDLE) ----------------
    logic            is_signed;
    logic            rs1_neg, rs2_neg;
    logic [XLEN-1:0] rs1_mag, rs2_mag;
    logic            div_zero, sgn_ovf, fast_path, accept;
    logic [XLEN-1:0] fast_result;

    always_comb begin
        is_signed   = ~E_div_op_i[0];
        rs1_neg     = is_signed & E_rs1_data_i[XLEN-1];
        rs2_neg     = is_signed & E_rs2_data_i[XLEN-1];
        rs1_mag     = rs1_neg ? -E_rs1_data_i : E_rs1_data_i;
        rs2_mag     = rs2_neg ? -E_rs2_data_i : E_rs2_data_i;
        div_zero    = (E_rs2_data_i == '0);
        sgn_ovf     = is_signed & (E_rs1_data_i == INT_MIN) & (E_rs2_data_i == '1);
        fast_path   = div_zero | sgn_ovf;
        accept      = (state_reg == S_IDLE) & E_div_start_i & ~E_flush_i;
        fast_result = '0;
        if (div_zero)
            fast_result = E_div_op_i[1] ? E_rs1_data_i : '1;
        else
            fast_result = E_div_op_i[1] ? '0 : INT_MIN;
    end

    // ---------------- one restoring step (CALC) ----------------
    // The shifted partial remainder is kept XLEN+1 bits wide: for divisors
    // with the MSB set the remainder can itself reach bit XLEN-1, and a
    // plain XLEN-bit shift would drop that bit.
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   rem_diff;
    logic            q_bit;
    logic [XLEN-1:0] rem_step;

    always_comb begin
        rem_shift = {rem_reg, dvd_reg[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, dvs_reg};
        q_bit     = ~rem_diff[XLEN];   // no borrow -> rem_shift >= divisor
        rem_step  = q_bit ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    end

    // ---------------- sign correction (FIX) ----------------
    logic [XLEN-1:0] quo_fix, rem_fix;

    always_comb begin
        quo_fix = q_neg_reg ? -dvd_reg : dvd_reg;
        rem_fix = r_neg_reg ? -rem_reg : rem_reg;
    end

    // ---------------- optional result cache ----------------
    logic            cache_hit;
    logic [XLEN-1:0] cache_result;

`ifdef DIV_RESULT_CACHE_EN
    logic            cache_valid_reg;
    logic [XLEN-1:0] cache_rs1_reg, cache_rs2_reg;
    logic            cache_signed_reg;
    logic [XLEN-1:0] cache_quo_reg, cache_rem_reg;
    logic [XLEN-1:0] op_rs1_reg, op_rs2_reg;   // raw operands of the op in flight

    always_comb begin
        cache_hit    = cache_valid_reg
                       & (E_rs1_data_i == cache_rs1_reg)
                       & (E_rs2_data_i == cache_rs2_reg)
                       & (is_signed == cache_signed_reg);
        cache_result = E_div_op_i[1] ? cache_rem_reg : cache_quo_reg;
    end

    // Only iterative completions fill the cache; hits and fast paths leave it.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            cache_valid_reg  <= 1'b0;
            cache_rs1_reg    <= '0;
            cache_rs2_reg    <= '0;
            cache_signed_reg <= 1'b0;
            cache_quo_reg    <= '0;
            cache_rem_reg    <= '0;
            op_rs1_reg       <= '0;
            op_rs2_reg       <= '0;
        end else begin
            if (accept) begin
                op_rs1_reg <= E_rs1_data_i;
                op_rs2_reg <= E_rs2_data_i;
            end
            if (state_reg == S_FIX && !E_flush_i) begin
                cache_valid_reg  <= 1'b1;
                cache_rs1_reg    <= op_rs1_reg;
                cache_rs2_reg    <= op_rs2_reg;
                cache_signed_reg <= ~op_reg[0];
                cache_quo_reg    <= quo_fix;
                cache_rem_reg    <= rem_fix;
            end
        end
    end
`else
    always_comb begin
        cache_hit    = 1'b0;
        cache_result = '0;
    end
`endif

    // ---------------- FSM and datapath ----------------
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            op_reg     <= '0;
            dvd_reg    <= '0;
            dvs_reg    <= '0;
            rem_reg    <= '0;
            cnt_reg    <= '0;
            q_neg_reg  <= 1'b0;
            r_neg_reg  <= 1'b0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        op_reg    <= E_div_op_i;
                        dvd_reg   <= rs1_mag;
                        dvs_reg   <= rs2_mag;
                        rem_reg   <= '0;
                        q_neg_reg <= rs1_neg ^ rs2_neg;
                        r_neg_reg <= rs1_neg;
                        cnt_reg   <= CNT_W'(XLEN);
                        if (fast_path) begin
                            result_reg <= fast_result;
                            state_reg  <= S_DONE;
                        end else if (cache_hit) begin
                            result_reg <= cache_result;
                            state_reg  <= S_DONE;
                        end else begin
                            state_reg  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (E_flush_i) begin
                        state_reg <= S_IDLE;
                    end else begin
                        rem_reg <= rem_step;
                        dvd_reg <= {dvd_reg[XLEN-2:0], q_bit};
                        cnt_reg <= cnt_reg - 1'b1;
                        if (cnt_reg == CNT_W'(1))
                            state_reg <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (E_flush_i) begin
                        state_reg <= S_IDLE;
                    end else begin
                        result_reg <= op_reg[1] ? rem_fix : quo_fix;
                        state_reg  <= S_DONE;
                    end
                end
                default: begin
                    // DONE: the pulse is already out, so start and flush are ignored
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign E_stall_o      = accept | (state_reg == S_CALC) | (state_reg == S_FIX);
    assign E_div_done_o   = (state_reg == S_DONE);
    assign E_div_result_o = result_reg;

endmodule

// File: tb/tb_execute_div.sv
module tb_execute_div;

    logic        clk_i = 1'b0;
    logic        rst;
    logic        E_div_start_i;
    logic [1:0]  E_div_op_i;
    logic [31:0] E_rs1_data_i;
    logic [31:0] E_rs2_data_i;
    logic        E_flush_i;
    logic        E_stall_o;
    logic        E_div_done_o;
    logic [31:0] E_div_result_o;

    execute_div #(.XLEN(32), .CNT_W(6)) dut (
        .clk_i          (clk_i),
        .rst            (rst),
        .E_div_start_i  (E_div_start_i),
        .E_div_op_i     (E_div_op_i),
        .E_rs1_data_i   (E_rs1_data_i),
        .E_rs2_data_i   (E_rs2_data_i),
        .E_flush_i      (E_flush_i),
        .E_stall_o      (E_stall_o),
        .E_div_done_o   (E_div_done_o),
        .E_div_result_o (E_div_result_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_REM  = 2'd2;
    localparam logic [1:0] OP_REMU = 2'd3;

    localparam int FULL_LAT = 34;
    localparam int FAST_LAT = 1;
`ifdef DIV_RESULT_CACHE_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = 34;
`endif

    typedef struct {
        logic [31:0] res;
        int          start_cyc;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    int   stall_cnt;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Scoreboard monitor: every done pulse is matched with the oldest expectation.
    always @(negedge clk_i) begin
        if (!rst && E_div_done_o) begin
            checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL unexpected_done: got done with result=%08h, none expected", E_div_result_o);
            end else begin
                mon_e = sb_q.pop_front();
                if (E_div_result_o === mon_e.res && (cyc - mon_e.start_cyc) == mon_e.lat
                    && E_stall_o === 1'b0) begin
                    passed++;
                    $display("txn %s: result=%08h latency=%0d", mon_e.name, E_div_result_o,
                             cyc - mon_e.start_cyc);
                end else begin
                    $display("FAIL %s: result=%08h latency=%0d stall=%b, required result=%08h latency=%0d stall=0",
                             mon_e.name, E_div_result_o, cyc - mon_e.start_cyc, E_stall_o,
                             mon_e.res, mon_e.lat);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %08h, required %08h", name, act, req);
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Presents one divide in the decode register and holds it until done.
    // Returns in the DONE cycle; stall_cnt counts stalled cycles after the start cycle.
    task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input int lat,
                         output int n_stall);
        bit got = 0;
        exp_t e;
        E_div_op_i    = op;
        E_rs1_data_i  = a;
        E_rs2_data_i  = b;
        E_div_start_i = 1'b1;
        e.res = res; e.start_cyc = cyc; e.lat = lat; e.name = name;
        sb_q.push_back(e);
        #1;
        check({name, "_stall_at_start"}, {31'd0, E_stall_o}, 32'd1);
        n_stall = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            next_cycle();
            if (E_div_done_o) got = 1;
            else if (E_stall_o) n_stall++;
        end
        if (!got) begin
            checks++;
            $display("FAIL %s_timeout: no done within 100 cycles, required done", name);
            if (sb_q.size() > 0) void'(sb_q.pop_back());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        E_div_start_i = 1'b0;
        E_div_op_i = 2'd0;
        E_rs1_data_i = '0;
        E_rs2_data_i = '0;
        E_flush_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_stall",  {31'd0, E_stall_o},    32'd0);
        check("reset_done",   {31'd0, E_div_done_o}, 32'd0);
        check("reset_result", E_div_result_o,        32'd0);
        rst = 1'b0;
        next_cycle();

        // Normal unsigned divide, then remainder back-to-back.
        issue("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, FULL_LAT, stall_cnt);
        check("divu_stall_cycles", stall_cnt, 32'd33);
        next_cycle();
        issue("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, HIT_LAT, stall_cnt);
        next_cycle();
        // Signed with negative dividend.
        issue("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, FULL_LAT, stall_cnt);
        next_cycle();
        issue("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, HIT_LAT, stall_cnt);
        next_cycle();
        // Fast paths.
        issue("div_by_zero", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, FAST_LAT, stall_cnt);
        next_cycle();
        issue("rem_by_zero", OP_REM, 32'd5, 32'd0, 32'd5, FAST_LAT, stall_cnt);
        next_cycle();
        issue("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, FAST_LAT, stall_cnt);
        next_cycle();
        issue("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, FAST_LAT, stall_cnt);
        next_cycle();
        // Large operands: divisor with the MSB set.
        issue("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, FULL_LAT, stall_cnt);
        next_cycle();
        issue("divu_max_big", OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, FULL_LAT, stall_cnt);
        next_cycle();
        issue("remu_max_big", OP_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, HIT_LAT, stall_cnt);
        next_cycle();

        // Flush with start in IDLE: flush wins, nothing starts.
        E_div_op_i = OP_DIVU; E_rs1_data_i = 32'd1000; E_rs2_data_i = 32'd3;
        E_div_start_i = 1'b1; E_flush_i = 1'b1;
        #1;
        check("flush_idle_stall", {31'd0, E_stall_o}, 32'd0);
        next_cycle();
        E_div_start_i = 1'b0; E_flush_i = 1'b0;
        #1;
        check("flush_idle_stays_idle", {31'd0, E_stall_o}, 32'd0);

        // Flush at CALC cycle 10.
        next_cycle();
        E_div_start_i = 1'b1;
        repeat (10) next_cycle();
        E_flush_i = 1'b1; E_div_start_i = 1'b0;
        next_cycle();
        E_flush_i = 1'b0;
        #1;
        check("flush_calc_stall", {31'd0, E_stall_o}, 32'd0);
        repeat (40) next_cycle();
        check("flush_result_kept", E_div_result_o, 32'd1);
        issue("divu_1000_3", OP_DIVU, 32'd1000, 32'd3, 32'd333, FULL_LAT, stall_cnt);
        next_cycle();

        // Asynchronous reset mid-CALC.
        E_div_op_i = OP_DIVU; E_rs1_data_i = 32'd50; E_rs2_data_i = 32'd5;
        E_div_start_i = 1'b1;
        repeat (5) next_cycle();
        #2;
        rst = 1'b1; E_div_start_i = 1'b0;
        #1;
        check("async_rst_stall",  {31'd0, E_stall_o},    32'd0);
        check("async_rst_done",   {31'd0, E_div_done_o}, 32'd0);
        check("async_rst_result", E_div_result_o,        32'd0);
        #3;
        rst = 1'b0;
        next_cycle();
        issue("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, FULL_LAT, stall_cnt);
        next_cycle();

        // Same operands, quotient then remainder.
        issue("div_100_7", OP_DIV, 32'd100, 32'd7, 32'd14, FULL_LAT, stall_cnt);
        next_cycle();
        issue("rem_100_7", OP_REM, 32'd100, 32'd7, 32'd2, HIT_LAT, stall_cnt);
        next_cycle();
        E_div_start_i = 1'b0;

        repeat (5) next_cycle();
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
